// File: rtl/ap_hs_launcher_if.sv
// Control-side bundle between the ap_ctrl_hs launcher, its host and the HLS kernel.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side, res_valid/res_ready on the result side.
//
// Ports (signals):
//   cmd_valid/cmd_ready/cmd_runs/cmd_alpha/cmd_beta : command from host
//   alpha/beta/ap_start                             : launcher -> kernel
//   ap_ready/ap_done/ap_idle                        : kernel -> launcher
//   res_valid/res_ready/res_latency/res_run_idx/res_timeout : per-run result to host
//   busy/err_spurious                               : status
// modport master = launcher side; modport slave = host + kernel side.
interface ap_hs_launcher_if #(
  parameter int CNT_W  = 32,
  parameter int RUNS_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [RUNS_W-1:0] cmd_runs;
  logic [31:0]       cmd_alpha;
  logic [31:0]       cmd_beta;
  logic [31:0]       alpha;
  logic [31:0]       beta;
  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_latency;
  logic [RUNS_W-1:0] res_run_idx;
  logic              res_timeout;
  logic              busy;
  logic              err_spurious;

  modport master (
    input  cmd_valid, cmd_runs, cmd_alpha, cmd_beta,
    input  ap_ready, ap_done, ap_idle, res_ready,
    output cmd_ready, alpha, beta, ap_start,
    output res_valid, res_latency, res_run_idx, res_timeout,
    output busy, err_spurious
  );

  modport slave (
    output cmd_valid, cmd_runs, cmd_alpha, cmd_beta,
    output ap_ready, ap_done, ap_idle, res_ready,
    input  cmd_ready, alpha, beta, ap_start,
    input  res_valid, res_latency, res_run_idx, res_timeout,
    input  busy, err_spurious
  );
endinterface

// File: rtl/ap_hs_launcher.sv
// Initiator for the ap_ctrl_hs block handshake: launches cmd_runs kernel runs, one result record per run.
// Latency: ap_start rises the cycle after command accept / result handshake; record valid the cycle after ap_done.
// Backpressure: cmd_ready only in IDLE; a result held by res_ready=0 stalls the next launch.
//
// Ports:
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset (deassertion expected synchronous to ap_clk)
//   bus      : ap_hs_launcher_if.master -- command, kernel ap_* controls, result record, status
module ap_hs_launcher #(
  parameter int CNT_W   = 32,
  parameter int RUNS_W  = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  ap_hs_launcher_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2,
    S_REPORT     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_LAT_MAX = '1;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_alpha, w_alpha_nxt;
  logic [31:0]       r_beta, w_beta_nxt;
  logic [RUNS_W-1:0] r_runs, w_runs_nxt;
  logic [RUNS_W-1:0] r_run_idx, w_run_idx_nxt;
  // r_lat counts the current run including the current cycle; it freezes in REPORT
  // and doubles as the res_latency field.
  logic [CNT_W-1:0]  r_lat, w_lat_nxt, w_lat_inc;
  logic              r_timeout, w_timeout_nxt;
  logic              r_err, w_err_nxt;
  logic              r_ap_start, r_res_valid, r_busy;
  logic              w_last_run, w_watchdog;
  logic              w_unused_idle;

  assign w_lat_inc     = (r_lat == LP_LAT_MAX) ? r_lat : r_lat + CNT_W'(1);
  assign w_last_run    = (r_run_idx == r_runs - RUNS_W'(1));
  assign w_watchdog    = (r_lat >= LP_TIMEOUT);
  // ap_idle is status only; nothing in the sequencing depends on it.
  assign w_unused_idle = bus.ap_idle;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_alpha_nxt   = r_alpha;
    w_beta_nxt    = r_beta;
    w_runs_nxt    = r_runs;
    w_run_idx_nxt = r_run_idx;
    w_lat_nxt     = r_lat;
    w_timeout_nxt = r_timeout;
    w_err_nxt     = r_err;

    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_alpha_nxt   = bus.cmd_alpha;
          w_beta_nxt    = bus.cmd_beta;
          w_runs_nxt    = bus.cmd_runs;
          w_run_idx_nxt = '0;
          w_err_nxt     = 1'b0;
          if (bus.cmd_runs != '0) begin
            w_lat_nxt     = CNT_W'(1);
            w_timeout_nxt = 1'b0;
            w_state_nxt   = S_WAIT_START;
          end
        end
      end

      S_WAIT_START: begin
        // ap_done alone implies the inputs were consumed as well.
        if (bus.ap_done) begin
          w_state_nxt = S_REPORT;
        end else if (w_watchdog) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_REPORT;
        end else begin
          w_lat_nxt = w_lat_inc;
          if (bus.ap_ready) begin
            w_state_nxt = S_WAIT_DONE;
          end
        end
      end

      S_WAIT_DONE: begin
        if (bus.ap_done) begin
          w_state_nxt = S_REPORT;
        end else if (w_watchdog) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_REPORT;
        end else begin
          w_lat_nxt = w_lat_inc;
        end
      end

      S_REPORT: begin
        if (bus.res_ready) begin
          if (r_timeout || w_last_run) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_run_idx_nxt = r_run_idx + RUNS_W'(1);
            w_lat_nxt     = CNT_W'(1);
            w_state_nxt   = S_WAIT_START;
          end
        end
      end
    endcase

    // A done pulse while no run is outstanding is flagged; it wins over the clear
    // on a command accepted in the same cycle.
    if (bus.ap_done && (r_state == S_IDLE || r_state == S_REPORT)) begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_alpha     <= '0;
      r_beta      <= '0;
      r_runs      <= '0;
      r_run_idx   <= '0;
      r_lat       <= '0;
      r_timeout   <= 1'b0;
      r_err       <= 1'b0;
      r_ap_start  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_alpha     <= w_alpha_nxt;
      r_beta      <= w_beta_nxt;
      r_runs      <= w_runs_nxt;
      r_run_idx   <= w_run_idx_nxt;
      r_lat       <= w_lat_nxt;
      r_timeout   <= w_timeout_nxt;
      r_err       <= w_err_nxt;
      r_ap_start  <= (w_state_nxt == S_WAIT_START);
      r_res_valid <= (w_state_nxt == S_REPORT);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.cmd_ready    = (r_state == S_IDLE);
  assign bus.alpha        = r_alpha;
  assign bus.beta         = r_beta;
  assign bus.ap_start     = r_ap_start;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_latency  = r_lat;
  assign bus.res_run_idx  = r_run_idx;
  assign bus.res_timeout  = r_timeout;
  assign bus.busy         = r_busy;
  assign bus.err_spurious = r_err;

endmodule
